// File: rtl/data_mem_responder.sv
// MEM-stage data responder: shared single-port RAM, two-cycle CPU loads with a stall
// handshake, host loader port with priority, and a small STATUS/CYCLES/RESULT I/O window.
module data_mem_responder #(
    parameter int          DEPTH   = 256,
    parameter logic [31:0] IO_BASE = 32'h0000_0400
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    input  logic                     cpu_we,
    input  logic                     cpu_re,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_stall,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    input  logic [31:0]              host_wdata,
    output logic [31:0]              host_rdata,
    output logic                     host_ack,
    output logic                     done,
    output logic [31:0]              result
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, CPU_WAIT} state_t;

    state_t      state, state_next;
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] cycles;
    logic [31:0] load_value;
    logic        host_go, cpu_store, cpu_load;

    // Decode on the word address; the byte offset is irrelevant for word accesses.
    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          is_ram, is_status, is_cycles, is_result;
    logic [1:0]    unused_byte_offset;

    assign word_addr          = cpu_addr[31:2];
    assign ram_idx            = cpu_addr[AW+1:2];
    assign unused_byte_offset = cpu_addr[1:0];
    assign is_ram             = cpu_addr < 32'(DEPTH * 4);
    assign is_status          = word_addr == IO_BASE[31:2];
    assign is_cycles          = word_addr == IO_BASE[31:2] + 30'd1;
    assign is_result          = word_addr == IO_BASE[31:2] + 30'd2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so no path through this block leaves a variable unassigned (no latch).
        state_next = IDLE;
        if (state == IDLE && !host_req && !cpu_we && cpu_re)
            state_next = CPU_WAIT;
    end

    always_comb begin
        cpu_stall = 1'b0;
        host_go   = 1'b0;
        cpu_store = 1'b0;
        cpu_load  = 1'b0;
        case (state)
            IDLE: begin
                if (host_req) begin
                    host_go   = 1'b1;
                    cpu_stall = cpu_we | cpu_re;
                end else if (cpu_we) begin
                    cpu_store = 1'b1;
                end else if (cpu_re) begin
                    cpu_load  = 1'b1;
                    cpu_stall = 1'b1;
                end
            end
            CPU_WAIT: host_go = host_req;
            default: ;
        endcase
    end

    always_comb begin
        load_value = '0;
        if      (is_ram)    load_value = mem[ram_idx];
        else if (is_status) load_value = {31'b0, done};
        else if (is_cycles) load_value = cycles;
        else if (is_result) load_value = result;
    end

    // NOTE: the RAM array has no reset; contents deliberately survive a reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (host_go && host_we)
                mem[host_addr] <= host_wdata;
            else if (cpu_store && is_ram)
                mem[ram_idx] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q    <= '0;
            host_rdata <= '0;
            host_ack   <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            cycles     <= '0;
        end else begin
            host_ack <= host_go;
            if (host_go && !host_we)
                host_rdata <= mem[host_addr];
            if (cpu_load)
                rdata_q <= load_value;
            if (!done)
                cycles <= cycles + 32'd1;
            if (cpu_store && is_status && cpu_wdata[0])
                done <= 1'b1;
            if (cpu_store && is_result)
                result <= cpu_wdata;
        end
    end

    assign cpu_rdata = rdata_q;

endmodule
